// File: rtl/chnl_loopback_fifo.sv
// -----------------------------------------------------------------------------
// chnl_loopback_fifo
//
// RIFFA channel loopback engine. A host->FPGA transfer is accepted on the RX
// channel, each beat is optionally transformed (echo, or +1 on every 32-bit
// lane), buffered in a show-ahead FIFO and streamed back on the TX channel.
// TX starts as soon as the transfer is acknowledged, so RX and TX overlap.
// TX backpressure stalls RX through the FIFO full flag, so no data is lost.
//
// Parameters
//   C_PCI_DATA_WIDTH : beat width in bits (32, 64 or 128)
//   C_FIFO_DEPTH     : FIFO depth in beats (power of two, >= 2)
//   C_MODE           : 0 = echo, 1 = each 32-bit lane incremented by one
//
// Ports
//   CLK, RST                 : clock, synchronous active-high reset
//   CHNL_RX_CLK/CHNL_TX_CLK  : channel clocks, driven from CLK
//   CHNL_RX, CHNL_RX_ACK     : RX transfer request / one-cycle accept pulse
//   CHNL_RX_LEN              : RX length in 32-bit words
//   CHNL_RX_LAST/CHNL_RX_OFF : ignored
//   CHNL_RX_DATA(_VALID/_REN): RX beat stream
//   CHNL_TX, CHNL_TX_ACK     : TX transfer request / host ack (ignored)
//   CHNL_TX_LAST/CHNL_TX_OFF : constants 1 / 0
//   CHNL_TX_LEN              : length latched from RX
//   CHNL_TX_DATA(_VALID/_REN): TX beat stream, data is the FIFO head
//   BUSY                     : high from RX accept until last TX beat leaves
//   STAT_XFER_CNT            : completed transfer count (wraps)
// -----------------------------------------------------------------------------
module chnl_loopback_fifo #(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int C_FIFO_DEPTH     = 16,
    parameter int C_MODE           = 0
) (
    input  logic                        CLK,
    input  logic                        RST,
    output logic                        CHNL_RX_CLK,
    input  logic                        CHNL_RX,
    output logic                        CHNL_RX_ACK,
    input  logic                        CHNL_RX_LAST,
    input  logic [31:0]                 CHNL_RX_LEN,
    input  logic [30:0]                 CHNL_RX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    input  logic                        CHNL_RX_DATA_VALID,
    output logic                        CHNL_RX_DATA_REN,
    output logic                        CHNL_TX_CLK,
    output logic                        CHNL_TX,
    input  logic                        CHNL_TX_ACK,
    output logic                        CHNL_TX_LAST,
    output logic [31:0]                 CHNL_TX_LEN,
    output logic [30:0]                 CHNL_TX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
    output logic                        CHNL_TX_DATA_VALID,
    input  logic                        CHNL_TX_DATA_REN,
    output logic                        BUSY,
    output logic [31:0]                 STAT_XFER_CNT
);

    localparam int W     = C_PCI_DATA_WIDTH / 32;
    localparam int LOG2W = (W > 1) ? $clog2(W) : 0;
    localparam int AW    = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;

    localparam logic [31:0] LANE_MASK = 32'(W - 1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0] CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0] CNT_FULL  = (AW + 1)'(C_FIFO_DEPTH);
    localparam logic [AW:0] CNT_EMPTY = (AW + 1)'(0);

    localparam logic [0:0] RX_IDLE = 1'b0;
    localparam logic [0:0] RX_RECV = 1'b1;
    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_SEND = 1'b1;

    // A lane of the final beat beyond the transfer length carries no payload
    // and is forwarded untouched.
    function automatic logic lane_is_used(input logic        last_beat,
                                          input logic [31:0] rem_lanes,
                                          input logic [31:0] lane);
        logic used;
        if (last_beat && (rem_lanes != 32'd0) && (lane >= rem_lanes)) begin
            used = 1'b0;
        end else begin
            used = 1'b1;
        end
        return used;
    endfunction

    // Registered state
    logic [0:0]                  rx_state_q, rx_state_d;
    logic [0:0]                  tx_state_q, tx_state_d;
    logic [31:0]                 len_q, len_d;
    logic [31:0]                 nbeats_q, nbeats_d;
    logic [31:0]                 rx_cnt_q, rx_cnt_d;
    logic [31:0]                 tx_cnt_q, tx_cnt_d;
    logic [31:0]                 xfer_cnt_q, xfer_cnt_d;
    logic                        rx_ack_q, rx_ack_d;
    logic                        busy_q, busy_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [AW:0]                 count_q, count_d;
    logic                        full_q, full_d;
    logic                        empty_q, empty_d;
    logic [C_PCI_DATA_WIDTH-1:0] fifo_mem_q [C_FIFO_DEPTH];

    // Combinational helpers
    logic                        start_s;
    logic                        rx_ren_s;
    logic                        rx_accept_s;
    logic                        rx_last_s;
    logic                        tx_valid_s;
    logic                        tx_pop_s;
    logic                        tx_last_s;
    logic [31:0]                 nbeats_in_s;
    logic [31:0]                 rem_lanes_s;
    logic [C_PCI_DATA_WIDTH-1:0] push_data_s;
    logic                        unused_s;

    assign unused_s = ^{CHNL_RX_LAST, CHNL_RX_OFF, CHNL_TX_ACK};

    // A new transfer is only taken when both directions are idle; the ack
    // guard stops a still-high CHNL_RX from re-triggering a zero-length accept.
    assign start_s     = (rx_state_q == RX_IDLE) && (tx_state_q == TX_IDLE) &&
                         CHNL_RX && !rx_ack_q;
    assign nbeats_in_s = (CHNL_RX_LEN + LANE_MASK) >> LOG2W;
    assign rx_ren_s    = (rx_state_q == RX_RECV) && !full_q;
    assign rx_accept_s = rx_ren_s && CHNL_RX_DATA_VALID;
    assign rx_last_s   = ((rx_cnt_q + 32'd1) == nbeats_q);
    assign tx_valid_s  = (tx_state_q == TX_SEND) && !empty_q;
    assign tx_pop_s    = tx_valid_s && CHNL_TX_DATA_REN;
    assign tx_last_s   = ((tx_cnt_q + 32'd1) == nbeats_q);
    assign rem_lanes_s = len_q & LANE_MASK;

    // Outputs
    assign CHNL_RX_CLK        = CLK;
    assign CHNL_TX_CLK        = CLK;
    assign CHNL_RX_ACK        = rx_ack_q;
    assign CHNL_RX_DATA_REN   = rx_ren_s;
    assign CHNL_TX            = (tx_state_q == TX_SEND);
    assign CHNL_TX_LAST       = 1'b1;
    assign CHNL_TX_OFF        = 31'd0;
    assign CHNL_TX_LEN        = len_q;
    assign CHNL_TX_DATA       = fifo_mem_q[rd_ptr_q];
    assign CHNL_TX_DATA_VALID = tx_valid_s;
    assign BUSY               = busy_q;
    assign STAT_XFER_CNT      = xfer_cnt_q;

    // Payload transform applied on the way into the FIFO
    always_comb begin
        push_data_s = CHNL_RX_DATA;
        for (int l = 0; l < W; l++) begin
            if ((C_MODE == 1) && lane_is_used(rx_last_s, rem_lanes_s, 32'(l))) begin
                push_data_s[32*l +: 32] = CHNL_RX_DATA[32*l +: 32] + 32'd1;
            end else begin
                push_data_s[32*l +: 32] = CHNL_RX_DATA[32*l +: 32];
            end
        end
    end

    // RX FSM next state: accept request, count beats into the FIFO
    always_comb begin
        rx_state_d = rx_state_q;
        len_d      = len_q;
        nbeats_d   = nbeats_q;
        rx_cnt_d   = rx_cnt_q;
        rx_ack_d   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (start_s) begin
                    rx_ack_d = 1'b1;
                    len_d    = CHNL_RX_LEN;
                    nbeats_d = nbeats_in_s;
                    rx_cnt_d = 32'd0;
                    if (CHNL_RX_LEN != 32'd0) begin
                        rx_state_d = RX_RECV;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_RECV: begin
                if (rx_accept_s) begin
                    rx_cnt_d = rx_cnt_q + 32'd1;
                    if (rx_last_s) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_RECV;
                    end
                end else begin
                    rx_state_d = RX_RECV;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // TX FSM next state, busy flag and completed-transfer counter
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        xfer_cnt_d = xfer_cnt_q;
        busy_d     = busy_q;
        // Zero-length transfers complete at accept time; start_s implies
        // TX is idle, so this never collides with the last-pop increment.
        if (start_s) begin
            if (CHNL_RX_LEN == 32'd0) begin
                xfer_cnt_d = xfer_cnt_q + 32'd1;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = busy_q;
        end
        case (tx_state_q)
            TX_IDLE: begin
                if (rx_ack_q && (len_q != 32'd0)) begin
                    tx_state_d = TX_SEND;
                    tx_cnt_d   = 32'd0;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_SEND: begin
                if (tx_pop_s) begin
                    tx_cnt_d = tx_cnt_q + 32'd1;
                    if (tx_last_s) begin
                        tx_state_d = TX_IDLE;
                        xfer_cnt_d = xfer_cnt_q + 32'd1;
                        busy_d     = 1'b0;
                    end else begin
                        tx_state_d = TX_SEND;
                    end
                end else begin
                    tx_state_d = TX_SEND;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // FIFO pointers, occupancy and registered full/empty flags
    always_comb begin
        if (rx_accept_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (tx_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({rx_accept_s, tx_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == CNT_EMPTY);
    end

    // State registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_state_q <= RX_IDLE;
            tx_state_q <= TX_IDLE;
            len_q      <= 32'd0;
            nbeats_q   <= 32'd0;
            rx_cnt_q   <= 32'd0;
            tx_cnt_q   <= 32'd0;
            xfer_cnt_q <= 32'd0;
            rx_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            tx_state_q <= tx_state_d;
            len_q      <= len_d;
            nbeats_q   <= nbeats_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            xfer_cnt_q <= xfer_cnt_d;
            rx_ack_q   <= rx_ack_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so
    // reset clears the pointers rather than the array
    always_ff @(posedge CLK) begin
        if (rx_accept_s) begin
            fifo_mem_q[wr_ptr_q] <= push_data_s;
        end
    end

endmodule

// File: tb/tb_chnl_loopback_fifo.sv
module tb_chnl_loopback_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    // DUT A: 32-bit, depth 4, echo
    logic        a_rx_clk, a_rx, a_rx_ack, a_rx_last, a_rx_valid, a_rx_ren;
    logic [31:0] a_rx_len, a_rx_data;
    logic [30:0] a_rx_off;
    logic        a_tx_clk, a_tx, a_tx_ack, a_tx_last, a_tx_valid, a_tx_ren, a_busy;
    logic [31:0] a_tx_len, a_tx_data, a_stat;
    logic [30:0] a_tx_off;

    // DUT B: 64-bit, depth 4, increment mode
    logic        b_rx_clk, b_rx, b_rx_ack, b_rx_last, b_rx_valid, b_rx_ren;
    logic [31:0] b_rx_len;
    logic [63:0] b_rx_data;
    logic [30:0] b_rx_off;
    logic        b_tx_clk, b_tx, b_tx_ack, b_tx_last, b_tx_valid, b_tx_ren, b_busy;
    logic [31:0] b_tx_len, b_stat;
    logic [63:0] b_tx_data;
    logic [30:0] b_tx_off;

    chnl_loopback_fifo #(.C_PCI_DATA_WIDTH(32), .C_FIFO_DEPTH(4), .C_MODE(0)) dut_a (
        .CLK(clk), .RST(rst),
        .CHNL_RX_CLK(a_rx_clk), .CHNL_RX(a_rx), .CHNL_RX_ACK(a_rx_ack),
        .CHNL_RX_LAST(a_rx_last), .CHNL_RX_LEN(a_rx_len), .CHNL_RX_OFF(a_rx_off),
        .CHNL_RX_DATA(a_rx_data), .CHNL_RX_DATA_VALID(a_rx_valid), .CHNL_RX_DATA_REN(a_rx_ren),
        .CHNL_TX_CLK(a_tx_clk), .CHNL_TX(a_tx), .CHNL_TX_ACK(a_tx_ack),
        .CHNL_TX_LAST(a_tx_last), .CHNL_TX_LEN(a_tx_len), .CHNL_TX_OFF(a_tx_off),
        .CHNL_TX_DATA(a_tx_data), .CHNL_TX_DATA_VALID(a_tx_valid), .CHNL_TX_DATA_REN(a_tx_ren),
        .BUSY(a_busy), .STAT_XFER_CNT(a_stat)
    );

    chnl_loopback_fifo #(.C_PCI_DATA_WIDTH(64), .C_FIFO_DEPTH(4), .C_MODE(1)) dut_b (
        .CLK(clk), .RST(rst),
        .CHNL_RX_CLK(b_rx_clk), .CHNL_RX(b_rx), .CHNL_RX_ACK(b_rx_ack),
        .CHNL_RX_LAST(b_rx_last), .CHNL_RX_LEN(b_rx_len), .CHNL_RX_OFF(b_rx_off),
        .CHNL_RX_DATA(b_rx_data), .CHNL_RX_DATA_VALID(b_rx_valid), .CHNL_RX_DATA_REN(b_rx_ren),
        .CHNL_TX_CLK(b_tx_clk), .CHNL_TX(b_tx), .CHNL_TX_ACK(b_tx_ack),
        .CHNL_TX_LAST(b_tx_last), .CHNL_TX_LEN(b_tx_len), .CHNL_TX_OFF(b_tx_off),
        .CHNL_TX_DATA(b_tx_data), .CHNL_TX_DATA_VALID(b_tx_valid), .CHNL_TX_DATA_REN(b_tx_ren),
        .BUSY(b_busy), .STAT_XFER_CNT(b_stat)
    );

    logic [63:0] rxq [$];
    logic [31:0] txa [$];
    logic [63:0] txb [$];

    // Collect every beat the TX side hands over (pop happens at next posedge)
    always @(negedge clk) begin
        if (!rst && a_tx_valid && a_tx_ren) txa.push_back(a_tx_data);
        if (!rst && b_tx_valid && b_tx_ren) txb.push_back(b_tx_data);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rx, input logic [31:0] len, input logic txren);
        logic        v;
        logic [63:0] d;
        v = (rxq.size() > 0);
        d = v ? rxq[0] : 64'd0;
        if (sel == 0) begin
            a_rx = rx; a_rx_len = len; a_rx_valid = v; a_rx_data = d[31:0]; a_tx_ren = txren;
        end else begin
            b_rx = rx; b_rx_len = len; b_rx_valid = v; b_rx_data = d; b_tx_ren = txren;
        end
    endtask

    // Runs one transfer on DUT sel using beats in rxq; TX_REN low for `hold` cycles.
    task automatic run_xfer(input int sel, input logic [31:0] len, input int hold, input int abort,
                            output logic ack_seen, output logic tx_seen, output int acc_hold,
                            output int lat, output logic ren_late);
        logic        done, txren, ack_now, ren_now, txv_now, txreq_now;
        logic [63:0] dummy;
        int          acc, first_acc, first_vld;
        ack_seen = 1'b0; tx_seen = 1'b0; acc_hold = 0; acc = 0;
        first_acc = -1; first_vld = -1; done = 1'b0; ren_late = 1'b1;
        txren = (hold == 0);
        drive(sel, 1'b1, len, txren);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            if (sel == 0) begin
                ack_now = a_rx_ack; ren_now = a_rx_ren; txv_now = a_tx_valid; txreq_now = a_tx;
            end else begin
                ack_now = b_rx_ack; ren_now = b_rx_ren; txv_now = b_tx_valid; txreq_now = b_tx;
            end
            if (txreq_now) tx_seen = 1'b1;
            if (txv_now && first_vld < 0) first_vld = cyc;
            if (cyc == hold - 1) ren_late = ren_now;
            if (rxq.size() > 0 && ren_now) begin
                acc++;
                if (!txren) acc_hold++;
                if (first_acc < 0) first_acc = cyc;
                dummy = rxq.pop_front();
            end
            if (ack_seen && rxq.size() == 0 && !txreq_now) done = 1'b1;
            if (ack_now) ack_seen = 1'b1;
            if (abort > 0 && acc == abort) done = 1'b1;
            if (!done) begin
                @(posedge clk); #1;
                txren = (cyc + 1 >= hold);
                drive(sel, !ack_seen, len, txren);
            end
        end
        check("xfer_completes_in_budget", {63'd0, done}, 64'd1);
        lat = first_vld - first_acc;
    endtask

    logic ack_s, txs_s, renl_s;
    int   acch_s, lat_s;

    initial begin
        rst = 1'b1;
        a_rx = 1'b0; a_rx_last = 1'b0; a_rx_len = 32'd0; a_rx_off = 31'd0; a_rx_data = 32'd0;
        a_rx_valid = 1'b0; a_tx_ack = 1'b0; a_tx_ren = 1'b0;
        b_rx = 1'b0; b_rx_last = 1'b0; b_rx_len = 32'd0; b_rx_off = 31'd0; b_rx_data = 64'd0;
        b_rx_valid = 1'b0; b_tx_ack = 1'b0; b_tx_ren = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ack",      {63'd0, a_rx_ack},   64'd0);
        check("rst_rx_ren",   {63'd0, a_rx_ren},   64'd0);
        check("rst_tx",       {63'd0, a_tx},       64'd0);
        check("rst_tx_valid", {63'd0, a_tx_valid}, 64'd0);
        check("rst_busy",     {63'd0, a_busy},     64'd0);
        check("rst_tx_len",   {32'd0, a_tx_len},   64'd0);
        check("rst_stat",     {32'd0, a_stat},     64'd0);
        check("tx_last_const",{63'd0, a_tx_last},  64'd1);
        check("tx_off_const", {33'd0, a_tx_off},   64'd0);
        check("b_rst_stat",   {32'd0, b_stat},     64'd0);
        check("rx_clk_follow",{63'd0, a_rx_clk},   {63'd0, clk});
        check("tx_clk_follow",{63'd0, b_tx_clk},   {63'd0, clk});

        // Test 1: W=1 echo, len=4
        rxq = '{64'd1, 64'd2, 64'd3, 64'd4};
        txa.delete();
        run_xfer(0, 32'd4, 0, 0, ack_s, txs_s, acch_s, lat_s, renl_s);
        check("t1_count", 64'(txa.size()), 64'd4);
        for (int i = 0; i < 4; i++) check("t1_data", {32'd0, txa[i]}, 64'(i + 1));
        check("t1_tx_len",  {32'd0, a_tx_len}, 64'd4);
        check("t1_tx_low",  {63'd0, a_tx},     64'd0);
        check("t1_stat",    {32'd0, a_stat},   64'd1);
        check("t1_busy",    {63'd0, a_busy},   64'd0);
        check("t1_latency", 64'(lat_s),        64'd1);

        // Test 2: W=2, increment mode, len=5, partial last beat keeps upper lane
        rxq = '{64'h00000002_00000001, 64'h00000004_00000003, 64'hDEADBEEF_00000005};
        txb.delete();
        run_xfer(1, 32'd5, 0, 0, ack_s, txs_s, acch_s, lat_s, renl_s);
        check("t2_count", 64'(txb.size()), 64'd3);
        check("t2_beat0", txb[0], 64'h00000003_00000002);
        check("t2_beat1", txb[1], 64'h00000005_00000004);
        check("t2_beat2", txb[2], 64'hDEADBEEF_00000006);
        check("t2_tx_len", {32'd0, b_tx_len}, 64'd5);
        check("t2_stat",   {32'd0, b_stat},   64'd1);
        check("t2_busy",   {63'd0, b_busy},   64'd0);

        // Test 4: increment wraps modulo 2^32 per lane
        rxq = '{64'h00000001_FFFFFFFF};
        txb.delete();
        run_xfer(1, 32'd2, 0, 0, ack_s, txs_s, acch_s, lat_s, renl_s);
        check("t4_count", 64'(txb.size()), 64'd1);
        check("t4_beat0", txb[0], 64'h00000002_00000000);
        check("t4_stat",  {32'd0, b_stat}, 64'd2);

        // Test 3: backpressure, depth 4, len=16, TX_REN low for 20 cycles
        rxq.delete();
        for (int i = 0; i < 16; i++) rxq.push_back(64'(32'h100 + i));
        txa.delete();
        run_xfer(0, 32'd16, 20, 0, ack_s, txs_s, acch_s, lat_s, renl_s);
        check("t3_acc_while_held", 64'(acch_s), 64'd4);
        check("t3_ren_low_full",   {63'd0, renl_s}, 64'd0);
        check("t3_count", 64'(txa.size()), 64'd16);
        for (int i = 0; i < 16; i++) check("t3_data", {32'd0, txa[i]}, 64'(32'h100 + i));
        check("t3_stat", {32'd0, a_stat}, 64'd2);

        // Test 5: zero length, then len=2
        rxq.delete();
        txa.delete();
        run_xfer(0, 32'd0, 0, 0, ack_s, txs_s, acch_s, lat_s, renl_s);
        check("t5_ack",   {63'd0, ack_s}, 64'd1);
        check("t5_no_tx", {63'd0, txs_s}, 64'd0);
        check("t5_stat",  {32'd0, a_stat}, 64'd3);
        rxq = '{64'h0000_00A1, 64'h0000_00A2};
        run_xfer(0, 32'd2, 0, 0, ack_s, txs_s, acch_s, lat_s, renl_s);
        check("t5b_count", 64'(txa.size()), 64'd2);
        check("t5b_beat0", {32'd0, txa[0]}, 64'h0000_00A1);
        check("t5b_beat1", {32'd0, txa[1]}, 64'h0000_00A2);
        check("t5b_stat",  {32'd0, a_stat}, 64'd4);

        // Test 6: reset after 2 of 8 beats, then len=3
        rxq.delete();
        for (int i = 0; i < 8; i++) rxq.push_back(64'(32'h200 + i));
        run_xfer(0, 32'd8, 0, 2, ack_s, txs_s, acch_s, lat_s, renl_s);
        @(posedge clk); #1;
        rst = 1'b1; a_rx = 1'b0; a_rx_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_ack",      {63'd0, a_rx_ack},   64'd0);
        check("t6_rx_ren",   {63'd0, a_rx_ren},   64'd0);
        check("t6_tx",       {63'd0, a_tx},       64'd0);
        check("t6_tx_valid", {63'd0, a_tx_valid}, 64'd0);
        check("t6_busy",     {63'd0, a_busy},     64'd0);
        check("t6_tx_len",   {32'd0, a_tx_len},   64'd0);
        check("t6_stat",     {32'd0, a_stat},     64'd0);
        rxq = '{64'h0000_0301, 64'h0000_0302, 64'h0000_0303};
        txa.delete();
        run_xfer(0, 32'd3, 0, 0, ack_s, txs_s, acch_s, lat_s, renl_s);
        check("t6b_count", 64'(txa.size()), 64'd3);
        check("t6b_beat0", {32'd0, txa[0]}, 64'h0000_0301);
        check("t6b_beat1", {32'd0, txa[1]}, 64'h0000_0302);
        check("t6b_beat2", {32'd0, txa[2]}, 64'h0000_0303);
        check("t6b_stat",  {32'd0, a_stat}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
